// File: rtl/dma_burst_controller.sv
// Custom-instruction programmed DMA sequencer: moves blocks between the CI scratchpad
// (port B) and the system bus as a series of bursts, acting as bus master.
module dma_burst_controller #(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic [8:0]  memAddressB,
  output logic        memWriteEnableB,
  output logic [31:0] memDataToRamB,
  input  logic [31:0] memDataFromRamB,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        readNotWriteOut,
  output logic [7:0]  burstSizeOut,
  output logic [3:0]  byteEnablesOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busyIn,
  input  logic        errorIn
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BEGIN, S_RD_DATA, S_WR_PREF, S_WR_DATA, S_WR_END, S_NEXT
  } state_t;

  localparam logic [2:0] SEL_BUS_ADDR = 3'd1;
  localparam logic [2:0] SEL_MEM_ADDR = 3'd2;
  localparam logic [2:0] SEL_BLOCK    = 3'd3;
  localparam logic [2:0] SEL_BURST    = 3'd4;
  localparam logic [2:0] SEL_CTRL     = 3'd5;

  state_t      state, state_next;

  logic [31:0] bus_addr_cfg;
  logic [8:0]  mem_addr_cfg;
  logic [9:0]  block_size;
  logic [7:0]  burst_size;
  logic        error_flag;
  logic        dir_read;

  logic [31:0] b_addr;
  logic [8:0]  m_addr;
  logic [9:0]  remaining;
  logic [8:0]  cur_beats;
  logic [8:0]  beat_cnt;

  logic        active, ci_write, busy, cfg_write;
  logic [2:0]  sel;
  logic        start_rd, start_wr, start_xfer, abort;
  logic        rd_beat, wr_accept;
  logic [8:0]  beats_now, beats_m1;
  logic [31:0] read_val;
  logic        unused_bits;

  // Beats in the next burst: the whole remainder if it fits, else a full burst.
  function automatic logic [8:0] burst_beats(input logic [9:0] rem, input logic [7:0] bsz);
    logic [9:0] full;
    full = {2'b00, bsz} + 10'd1;
    return (rem < full) ? rem[8:0] : full[8:0];
  endfunction

  assign active     = start && (ciN == customId);
  assign ci_write   = valueA[9];
  assign sel        = valueA[12:10];
  assign busy       = (state != S_IDLE);
  assign cfg_write  = active && ci_write && !busy;
  assign start_rd   = cfg_write && (sel == SEL_CTRL) && valueB[0];
  assign start_wr   = cfg_write && (sel == SEL_CTRL) && valueB[1];
  assign start_xfer = (start_rd || start_wr) && (block_size != 10'd0);
  assign abort      = busy && errorIn;

  assign beats_now  = burst_beats(remaining, burst_size);
  assign beats_m1   = beats_now - 9'd1;
  assign rd_beat    = (state == S_RD_DATA) && dataValidIn && (beat_cnt != 9'd0);
  assign wr_accept  = (state == S_WR_DATA) && !busyIn;

  assign unused_bits = ^{valueA[31:13], valueA[8:0], beats_m1[8]};

  always_comb begin
    read_val = 32'd0;
    case (sel)
      SEL_BUS_ADDR: read_val = bus_addr_cfg;
      SEL_MEM_ADDR: read_val = {23'd0, mem_addr_cfg};
      SEL_BLOCK:    read_val = {22'd0, block_size};
      SEL_BURST:    read_val = {24'd0, burst_size};
      SEL_CTRL:     read_val = {30'd0, error_flag, busy};
      default:      read_val = 32'd0;
    endcase
  end

  assign done   = active && !reset;
  assign result = (active && !ci_write && !reset) ? read_val : 32'd0;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start_xfer) state_next = S_REQ;
        S_REQ:     if (transactionGranted) state_next = S_BEGIN;
        S_BEGIN:   state_next = dir_read ? S_RD_DATA : S_WR_PREF;
        S_RD_DATA: if (endTransactionIn) state_next = S_NEXT;
        S_WR_PREF: state_next = S_WR_DATA;
        S_WR_DATA: if (wr_accept && (beat_cnt == 9'd1)) state_next = S_WR_END;
        S_WR_END:  state_next = S_NEXT;
        S_NEXT:    state_next = (remaining == 10'd0) ? S_IDLE : S_REQ;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    memAddressB         = 9'd0;
    memWriteEnableB     = 1'b0;
    memDataToRamB       = 32'd0;
    requestTransaction  = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = 32'd0;
    readNotWriteOut     = 1'b0;
    burstSizeOut        = 8'd0;
    byteEnablesOut      = 4'h0;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;
    case (state)
      S_REQ: requestTransaction = 1'b1;
      S_BEGIN: begin
        requestTransaction  = 1'b1;
        beginTransactionOut = 1'b1;
        addressDataOut      = b_addr;
        readNotWriteOut     = dir_read;
        burstSizeOut        = beats_m1[7:0];
        byteEnablesOut      = 4'hF;
      end
      S_RD_DATA: begin
        requestTransaction = 1'b1;
        memAddressB        = m_addr;
        if (rd_beat && !errorIn) begin
          memWriteEnableB = 1'b1;
          memDataToRamB   = addressDataIn;
        end
      end
      S_WR_PREF: begin
        requestTransaction = 1'b1;
        memAddressB        = m_addr;
      end
      S_WR_DATA: begin
        requestTransaction = 1'b1;
        addressDataOut     = memDataFromRamB;
        dataValidOut       = 1'b1;
        // Re-reading the same word while stalled keeps the bus data stable.
        memAddressB        = busyIn ? m_addr : m_addr + 9'd1;
      end
      S_WR_END: begin
        requestTransaction = 1'b1;
        endTransactionOut  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_addr_cfg <= 32'd0;
      mem_addr_cfg <= 9'd0;
      block_size   <= 10'd0;
      burst_size   <= 8'd0;
      error_flag   <= 1'b0;
      dir_read     <= 1'b0;
      b_addr       <= 32'd0;
      m_addr       <= 9'd0;
      remaining    <= 10'd0;
      cur_beats    <= 9'd0;
      beat_cnt     <= 9'd0;
    end else begin
      if (cfg_write) begin
        case (sel)
          SEL_BUS_ADDR: bus_addr_cfg <= {valueB[31:2], 2'b00};
          SEL_MEM_ADDR: mem_addr_cfg <= valueB[8:0];
          SEL_BLOCK:    block_size   <= valueB[9:0];
          SEL_BURST:    burst_size   <= valueB[7:0];
          default: ;
        endcase
      end
      if (start_xfer) begin
        b_addr     <= bus_addr_cfg;
        m_addr     <= mem_addr_cfg;
        remaining  <= block_size;
        error_flag <= 1'b0;
        dir_read   <= start_rd;
      end else if (abort) begin
        error_flag <= 1'b1;
      end else begin
        case (state)
          S_BEGIN: begin
            cur_beats <= beats_now;
            beat_cnt  <= beats_now;
          end
          S_RD_DATA: if (rd_beat) begin
            m_addr    <= m_addr + 9'd1;
            remaining <= remaining - 10'd1;
            beat_cnt  <= beat_cnt - 9'd1;
          end
          S_WR_DATA: if (wr_accept) begin
            m_addr    <= m_addr + 9'd1;
            remaining <= remaining - 10'd1;
            beat_cnt  <= beat_cnt - 9'd1;
          end
          S_NEXT: b_addr <= b_addr + {21'd0, cur_beats, 2'b00};
          default: ;
        endcase
      end
    end
  end

endmodule
